// File: rtl/ram_word_unpacker.sv
// rtl/ram_word_unpacker.sv - fetches words from the RAM wide read port and streams them as narrow beats, LSB first
module ram_word_unpacker #(
    parameter int WIDTHB     = 32,
    parameter int WIDTHO     = 8,
    parameter int ADDRWIDTHB = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDRWIDTHB-1:0] base_addr,
    input  logic [ADDRWIDTHB:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDRWIDTHB-1:0] ram_addr,
    output logic                  ram_re,
    input  logic [WIDTHB-1:0]     ram_do,
    output logic [WIDTHO-1:0]     m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);
    localparam int RATIO = WIDTHB / WIDTHO;
    localparam int BEATW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(RATIO - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_SEND} state_t;

    state_t              state;
    logic [WIDTHB-1:0]   word_reg;
    logic [BEATW-1:0]    beat_idx;
    logic [ADDRWIDTHB:0] remaining;
    logic [BEATW-1:0]    next_beat;
    logic                final_word;

    assign next_beat  = beat_idx + BEATW'(1);
    assign final_word = (remaining == (ADDRWIDTHB+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            word_reg  <= '0;
            beat_idx  <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_addr  <= '0;
            ram_re    <= 1'b0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            remaining <= word_count;
                            ram_addr  <= base_addr;
                            busy      <= 1'b1;
                            state     <= S_FETCH;
                        end
                    end
                end
                // RAM captures the addressed word into its read register at this exit edge
                S_FETCH: begin
                    ram_re <= 1'b1;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    ram_re <= 1'b0;
                    state  <= S_LOAD;
                end
                S_LOAD: begin
                    word_reg <= ram_do;
                    m_data   <= ram_do[WIDTHO-1:0];
                    m_valid  <= 1'b1;
                    m_last   <= final_word && (LAST_BEAT == '0);
                    beat_idx <= '0;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (m_ready) begin
                        if (beat_idx != LAST_BEAT) begin
                            beat_idx <= next_beat;
                            m_data   <= word_reg[32'(next_beat)*WIDTHO +: WIDTHO];
                            m_last   <= final_word && (next_beat == LAST_BEAT);
                        end else if (!final_word) begin
                            m_valid   <= 1'b0;
                            ram_addr  <= ram_addr + 1'b1;
                            remaining <= remaining - 1'b1;
                            state     <= S_FETCH;
                        end else begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_word_unpacker.sv
// tb/tb_ram_word_unpacker.sv - directed self-checking bench for ram_word_unpacker
module tb_ram_word_unpacker;
    logic        clk = 1'b0;
    logic        rst, start, busy, done, ram_re, m_valid, m_ready, m_last;
    logic [5:0]  base_addr, ram_addr;
    logic [6:0]  word_count;
    logic [31:0] ram_do;
    logic [7:0]  m_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ram_word_unpacker dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_re(ram_re), .ram_do(ram_do),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Port B model: address registered every edge, output register loads only when reB is high
    logic [31:0] mem [64];
    logic [31:0] read_reg;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        read_reg <= mem[ram_addr];
        if (ram_re) ram_do <= read_reg;
    end

    logic [7:0] beat_q[$];
    logic       last_q[$];
    int         beat_cyc[$];
    logic [5:0] re_addr_q[$];
    int         re_cyc[$];
    int         done_cnt = 0, done_cyc = 0, hold_bad = 0;
    logic       done_busy = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
                hold_bad++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready) begin
                beat_q.push_back(m_data);
                last_q.push_back(m_last);
                beat_cyc.push_back(cyc);
            end
            if (ram_re) begin
                re_addr_q.push_back(ram_addr);
                re_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
            end
        end
    end

    task automatic clear_log();
        beat_q.delete(); last_q.delete(); beat_cyc.delete();
        re_addr_q.delete(); re_cyc.delete();
        done_cnt = 0; hold_bad = 0; done_busy = 1'b0;
    endtask

    task automatic go(input logic [5:0] b, input logic [6:0] n, output int acc);
        start = 1'b1; base_addr = b; word_count = n;
        @(posedge clk); #1;
        start = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            if (done_cnt != 0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = '0; word_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (ram_re !== 1'b0)  begin errors++; $display("FAIL reset_ram_re got %b want 0", ram_re); end
        checks++; if (ram_addr !== 6'd0) begin errors++; $display("FAIL reset_ram_addr got %0d want 0", ram_addr); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if (m_last !== 1'b0)  begin errors++; $display("FAIL reset_m_last got %b want 0", m_last); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h want 00", m_data); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int acc; bit ok;
        mem[5] = 32'h44332211;
        clear_log(); m_ready = 1'b1;
        go(6'd5, 7'd1, acc);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        wait_done(50, ok);
        repeat (3) @(posedge clk); #1;
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout done not seen, want done within 50 cycles"); end
        checks++;
        if (re_addr_q.size() != 1 || re_addr_q[0] !== 6'd5 || re_cyc[0] != acc + 1) begin
            errors++; $display("FAIL single_ram_re count %0d addr %0d cyc %0d want 1/5/%0d",
                               re_addr_q.size(), re_addr_q[0], re_cyc[0], acc + 1);
        end
        checks++;
        if (beat_q.size() != 4 || {beat_q[3], beat_q[2], beat_q[1], beat_q[0]} !== 32'h44332211) begin
            errors++; $display("FAIL single_beats count %0d data %h%h%h%h want 4 44332211",
                               beat_q.size(), beat_q[3], beat_q[2], beat_q[1], beat_q[0]);
        end
        checks++;
        if ({last_q[3], last_q[2], last_q[1], last_q[0]} !== 4'b1000) begin
            errors++; $display("FAIL single_last got %b%b%b%b want 1000", last_q[3], last_q[2], last_q[1], last_q[0]);
        end
        checks++;
        if (beat_cyc[0] != acc + 3 || beat_cyc[3] != acc + 6) begin
            errors++; $display("FAIL single_latency first %0d last %0d want %0d %0d", beat_cyc[0], beat_cyc[3], acc + 3, acc + 6);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != acc + 7 || done_busy !== 1'b0) begin
            errors++; $display("FAIL single_done count %0d cyc %0d busy %b want 1 %0d 0", done_cnt, done_cyc, done_busy, acc + 7);
        end
    endtask

    task automatic test_wrap();
        int acc; bit ok; int bad;
        mem[62] = 32'h03020100; mem[63] = 32'h07060504; mem[0] = 32'h0B0A0908;
        clear_log(); m_ready = 1'b1;
        go(6'd62, 7'd3, acc);
        wait_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout done not seen, want done within 100 cycles"); end
        checks++;
        if (re_addr_q.size() != 3 || re_addr_q[0] !== 6'd62 || re_addr_q[1] !== 6'd63 || re_addr_q[2] !== 6'd0) begin
            errors++; $display("FAIL wrap_addr count %0d seq %0d %0d %0d want 3 62 63 0",
                               re_addr_q.size(), re_addr_q[0], re_addr_q[1], re_addr_q[2]);
        end
        bad = 0;
        for (int j = 0; j < 12; j++)
            if (beat_q[j] !== 8'(j) || last_q[j] !== (j == 11)) bad++;
        checks++;
        if (beat_q.size() != 12 || bad != 0) begin
            errors++; $display("FAIL wrap_beats count %0d bad %0d want 12 0", beat_q.size(), bad);
        end
        checks++;
        if (beat_cyc[4] - beat_cyc[0] != 7 || beat_cyc[8] - beat_cyc[4] != 7) begin
            errors++; $display("FAIL wrap_period got %0d %0d want 7 7", beat_cyc[4] - beat_cyc[0], beat_cyc[8] - beat_cyc[4]);
        end
    endtask

    task automatic test_backpressure();
        int acc; bit ok;
        logic [0:6] pat;
        pat = 7'b1001011;
        mem[5] = 32'h44332211;
        clear_log(); m_ready = 1'b0;
        go(6'd5, 7'd1, acc);
        repeat (3) begin @(posedge clk); #1; end
        for (int k = 0; k < 7; k++) begin
            m_ready = pat[k];
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout done not seen, want done within 50 cycles"); end
        checks++;
        if (beat_q.size() != 4 || {beat_q[3], beat_q[2], beat_q[1], beat_q[0]} !== 32'h44332211) begin
            errors++; $display("FAIL bp_beats count %0d data %h%h%h%h want 4 44332211",
                               beat_q.size(), beat_q[3], beat_q[2], beat_q[1], beat_q[0]);
        end
        checks++;
        if (beat_cyc[0] != acc + 3 || beat_cyc[1] != acc + 6 || beat_cyc[2] != acc + 8 || beat_cyc[3] != acc + 9) begin
            errors++; $display("FAIL bp_timing got %0d %0d %0d %0d want %0d %0d %0d %0d",
                               beat_cyc[0] - acc, beat_cyc[1] - acc, beat_cyc[2] - acc, beat_cyc[3] - acc, 3, 6, 8, 9);
        end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp_hold unstable cycles %0d want 0", hold_bad); end
    endtask

    task automatic test_zero_and_busy();
        int acc; bit ok;
        clear_log(); m_ready = 1'b1;
        go(6'd7, 7'd0, acc);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_done done %b busy %b want 1 0", done, busy);
        end
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (done_cnt != 1 || re_addr_q.size() != 0) begin
            errors++; $display("FAIL zero_quiet done_cnt %0d ram_re %0d want 1 0", done_cnt, re_addr_q.size());
        end
        mem[20] = 32'hA3A2A1A0; mem[21] = 32'hA7A6A5A4;
        clear_log();
        go(6'd20, 7'd2, acc);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; base_addr = 6'd40; word_count = 7'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100, ok);
        repeat (10) begin @(posedge clk); #1; end
        checks++; if (!ok) begin errors++; $display("FAIL busy_timeout done not seen, want done within 100 cycles"); end
        checks++;
        if (beat_q.size() != 8 || {beat_q[7], beat_q[6], beat_q[5], beat_q[4]} !== 32'hA7A6A5A4
            || {beat_q[3], beat_q[2], beat_q[1], beat_q[0]} !== 32'hA3A2A1A0) begin
            errors++; $display("FAIL busy_beats count %0d first %h last %h want 8 a0 a7", beat_q.size(), beat_q[0], beat_q[7]);
        end
        checks++;
        if (re_addr_q.size() != 2 || re_addr_q[0] !== 6'd20 || re_addr_q[1] !== 6'd21 || done_cnt != 1) begin
            errors++; $display("FAIL busy_ignore reads %0d done %0d want 2 1", re_addr_q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int acc; bit ok; bit hit;
        mem[30] = 32'h13121110; mem[31] = 32'h17161514; mem[32] = 32'h1B1A1918;
        clear_log(); m_ready = 1'b1;
        go(6'd30, 7'd3, acc);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk);
            if (beat_q.size() >= 7) hit = 1'b1;
        end
        #1; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (!hit) begin errors++; $display("FAIL rmid_timeout beats %0d want 7", beat_q.size()); end
        checks++;
        if ({busy, done, ram_re, m_valid, m_last, ram_addr, m_data} !== 19'd0) begin
            errors++; $display("FAIL rmid_outputs busy %b done %b re %b valid %b last %b addr %0d data %h want all 0",
                               busy, done, ram_re, m_valid, m_last, ram_addr, m_data);
        end
        rst = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (done_cnt != 0 || re_addr_q.size() != 2 || beat_q.size() != 7) begin
            errors++; $display("FAIL rmid_abort done %0d reads %0d beats %0d want 0 2 7", done_cnt, re_addr_q.size(), beat_q.size());
        end
        mem[50] = 32'hC3C2C1C0;
        clear_log();
        go(6'd50, 7'd1, acc);
        wait_done(50, ok);
        checks++;
        if (!ok || beat_q.size() != 4 || {beat_q[3], beat_q[2], beat_q[1], beat_q[0]} !== 32'hC3C2C1C0
            || re_addr_q.size() != 1 || re_addr_q[0] !== 6'd50) begin
            errors++; $display("FAIL rmid_restart done %b beats %0d first %h addr %0d want 1 4 c0 50",
                               ok, beat_q.size(), beat_q[0], re_addr_q[0]);
        end
    endtask

    task automatic test_full_depth();
        int acc; bit ok; int bad; int lasts; int abad;
        for (int a = 0; a < 64; a++)
            mem[a] = {8'(a * 4 + 3), 8'(a * 4 + 2), 8'(a * 4 + 1), 8'(a * 4)};
        clear_log(); m_ready = 1'b1;
        go(6'd10, 7'd64, acc);
        wait_done(1000, ok);
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (!ok) begin errors++; $display("FAIL full_timeout done not seen, want done within 1000 cycles"); end
        bad = 0; lasts = 0; abad = 0;
        for (int j = 0; j < beat_q.size(); j++) begin
            if (beat_q[j] !== 8'((40 + j) % 256)) bad++;
            if (last_q[j] === 1'b1) lasts++;
        end
        for (int w = 0; w < re_addr_q.size(); w++)
            if (re_addr_q[w] !== 6'((10 + w) % 64)) abad++;
        checks++;
        if (beat_q.size() != 256 || bad != 0) begin
            errors++; $display("FAIL full_beats count %0d bad %0d want 256 0", beat_q.size(), bad);
        end
        checks++;
        if (lasts != 1 || last_q[255] !== 1'b1 || done_cnt != 1) begin
            errors++; $display("FAIL full_last lasts %0d final %b done %0d want 1 1 1", lasts, last_q[255], done_cnt);
        end
        checks++;
        if (re_addr_q.size() != 64 || abad != 0) begin
            errors++; $display("FAIL full_addr reads %0d bad %0d want 64 0", re_addr_q.size(), abad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_zero_and_busy();
        test_reset_mid();
        test_full_depth();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/ram_word_unpacker.md
Name: ram_word_unpacker

Overview:
- Downstream consumer of the asymmetric-port RAM's wide read port (port B: 64x32, 2-cycle registered read with read-enable on the output register).
- On a start command, fetches a run of consecutive 32-bit words from port B and emits each word as 8-bit beats on a valid/ready stream, least-significant byte first.
- Byte order is the inverse of the RAM's narrow-write mapping, so bytes come out in the order they were written on port A.
- One clock domain; the RAM's clkB is tied to this block's clk.

Parameters:
- WIDTHB, 32, RAM read-port word width.
- WIDTHO, 8, output beat width; WIDTHB must be an integer multiple of WIDTHO; RATIO = WIDTHB/WIDTHO.
- ADDRWIDTHB, 6, RAM read-port address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDRWIDTHB  first word address; latched on accepted start.
- word_count  in  ADDRWIDTHB+1  number of words, 0..2^ADDRWIDTHB; latched on accepted start.
- busy  out  1  high from the edge that accepts start until the edge that returns to IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- ram_addr  out  ADDRWIDTHB  to RAM addrB.
- ram_re  out  1  to RAM reB.
- ram_do  in  WIDTHB  from RAM doB.
- m_data  out  WIDTHO  output beat.
- m_valid  out  1  beat valid.
- m_ready  in  1  sink ready; a beat transfers when m_valid && m_ready at a rising edge.
- m_last  out  1  marks the final beat of the run.

Behaviour:
- Reset: state IDLE; busy=0, done=0, ram_re=0, ram_addr=0, m_valid=0, m_last=0, m_data=0; internal counters cleared.
- Reset mid-operation: abort immediately to IDLE with reset values; no done pulse; no further ram_re; any pending word is discarded.
- All outputs are registered.
- States: IDLE, FETCH, WAIT, LOAD, SEND.
- IDLE, start=1, word_count=0: stay in IDLE; done=1 for the next cycle; no RAM access; busy stays 0.
- IDLE, start=1, word_count>0: latch the count; ram_addr<=base_addr; busy<=1; go to FETCH.
- FETCH (1 cycle): ram_addr stable; the RAM registers readB at the exiting edge; ram_re<=1; go to WAIT.
- WAIT (1 cycle): ram_re=1, so the RAM loads doB at the exiting edge; ram_re<=0; go to LOAD.
- LOAD (1 cycle): shift register<=ram_do; m_data<=ram_do[WIDTHO-1:0]; m_valid<=1; beat index<=0; go to SEND.
- m_last is set with a beat when it is beat RATIO-1 of the final word.
- SEND, on handshake, non-final beat: present the next byte (bits (k+1)*WIDTHO upward).
- SEND, on handshake, final beat of a non-final word: m_valid<=0; ram_addr<=ram_addr+1 (wraps modulo 2^ADDRWIDTHB); decrement remaining; go to FETCH.
- SEND, on handshake, final beat of the final word: m_valid<=0; m_last<=0; busy<=0; done<=1 for one cycle; go to IDLE.
- Backpressure: while m_valid=1 and m_ready=0, m_data and m_last hold stable and no state advances.
- m_ready is ignored when m_valid=0.
- Latency with m_ready held high: start accepted at edge E0; ram_re high between E1 and E2; first beat valid after E3.
- Per-word period is 3+RATIO cycles (7 at the defaults).
- done is asserted the cycle after the final handshake edge.
- start while busy=1 is ignored, with no effect on the run in progress.
- A start in the same cycle that done is high is accepted, because the state is IDLE in that cycle.
- ram_re is asserted exactly once per word, never outside WAIT.

Test Plan:
- Single word: RAM[5]=0x44332211; start with base_addr=5, word_count=1, m_ready=1 -> ram_addr=5; ram_re high for exactly 1 cycle; beats 0x11,0x22,0x33,0x44 on consecutive cycles starting 3 cycles after acceptance; m_last only on 0x44; done pulses 1 cycle later; busy falls with done.
- Wrap and multiword: base_addr=62, word_count=3; RAM[62]=0x03020100, RAM[63]=0x07060504, RAM[0]=0x0B0A0908 -> ram_addr sequence 62,63,0; beats 0x00..0x0B in order; m_last only on 0x0B; word period 7 cycles.
- Backpressure: same as the single-word case with m_ready toggled 1,0,0,1,0,1,1 -> each beat held stable while m_ready=0; exactly 4 transfers; no duplicated or skipped byte.
- Zero count and busy start: start with word_count=0 -> done one cycle later, no ram_re, busy=0; start pulsed mid-run of a 2-word transfer -> ignored, exactly 8 beats emitted.
- Reset mid-stream: assert rst after beat 2 of word 1 of a 3-word run -> next cycle all outputs at reset values, no done pulse; a new start then runs cleanly from its own base_addr.
- Full depth: word_count=64, base_addr=10 -> 256 beats; addresses run 10..63 then 0..9; single m_last and single done.
